// File: rtl/block_byte_repeater_if.sv
// Handshake bundle between the block producer, the byte repeater and the UART consumer.
// master: producer/consumer side; slave: the repeater itself.
interface block_byte_repeater_if #(
    parameter int REGISTER_SIZE = 32
);
    logic [REGISTER_SIZE-1:0] data_in;
    logic                     valid_in;
    logic                     request_next_byte_in;
    logic                     valid_out;
    logic [7:0]               data_out;
    logic                     frame_done_out;
    logic                     overflow_out;

    modport master (
        output data_in,
        output valid_in,
        output request_next_byte_in,
        input  valid_out,
        input  data_out,
        input  frame_done_out,
        input  overflow_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  request_next_byte_in,
        output valid_out,
        output data_out,
        output frame_done_out,
        output overflow_out
    );
endinterface

// File: rtl/block_byte_repeater.sv
// Buffers REGISTER_SIZE-bit blocks in a FIFO and replays them byte by byte to a UART.
// Define BYTE_REPEATER_MSB_FIRST_EN to send each block most-significant byte first.
module block_byte_repeater #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    parameter int FIFO_DEPTH    = BITS_IN_NUM / REGISTER_SIZE
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    block_byte_repeater_if.slave  bus
);

    localparam int NB = REGISTER_SIZE / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FB = BITS_IN_NUM / 8;
    localparam int FW = $clog2(FB);

    typedef enum logic {
        IDLE,
        WAIT_BUSY
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [FW-1:0]            frame_q, frame_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     valid_out_q, valid_out_d;
    logic [7:0]               data_out_q, data_out_d;
    logic                     frame_done_q, frame_done_d;
    logic                     overflow_q, overflow_d;
    logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic [REGISTER_SIZE-1:0] head;
    logic [IW-1:0]            sel;
    logic [7:0]               head_byte;

    // Pick the byte of the head block addressed by the current byte index.
    always_comb begin
        head = mem_q[rd_ptr_q];
`ifdef BYTE_REPEATER_MSB_FIRST_EN
        sel = IW'(NB - 1) - idx_q;
`else
        sel = idx_q;
`endif
        head_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (sel == IW'(i)) begin
                head_byte = head[i*8 +: 8];
            end
        end
    end

    // Byte sequencer: one pulse per consumer idle period, pop after the last byte.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        data_out_d   = data_out_q;
        pop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && bus.request_next_byte_in) begin
                    valid_out_d  = 1'b1;
                    data_out_d   = head_byte;
                    frame_done_d = (frame_q == FW'(FB - 1));
                    frame_d      = frame_done_d ? '0 : frame_q + 1'b1;
                    state_d      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.request_next_byte_in) begin
                    state_d = IDLE;
                    if (idx_q == IW'(NB - 1)) begin
                        idx_d = '0;
                        pop   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle makes room for a push into a full FIFO.
    always_comb begin
        full       = (cnt_q == CW'(FIFO_DEPTH));
        empty      = (cnt_q == '0);
        push       = bus.valid_in && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        overflow_d = overflow_q | (bus.valid_in && !push);
    end

    // Block storage; contents need no reset since the pointers discard them.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= 8'h00;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.valid_out      = valid_out_q;
    assign bus.data_out       = data_out_q;
    assign bus.frame_done_out = frame_done_q;
    assign bus.overflow_out   = overflow_q;

endmodule

// File: tb/tb_block_byte_repeater.sv
// Randomized bench for block_byte_repeater with a queue-based byte model and a UART model.
// Honours BYTE_REPEATER_MSB_FIRST_EN for the expected byte order.
module tb_block_byte_repeater;

    localparam int RS    = 32;
    localparam int BN    = 4096;
    localparam int DEPTH = BN / RS;
    localparam int NB    = RS / 8;
    localparam int FB    = BN / 8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    block_byte_repeater_if #(.REGISTER_SIZE(RS)) bus ();

    block_byte_repeater #(
        .REGISTER_SIZE(RS),
        .BITS_IN_NUM  (BN),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    initial forever #5 clk_in = ~clk_in;

    // model state
    logic [RS-1:0] blk_q [$];
    logic [7:0]    got [$];
    int            pcyc [$];
    int            fd_idx [$];
    int            occ, bpos, fc, busy, fixed_busy, cyc, last_push_cyc;
    bit            pop_pending, exp_ovf, stall;
    logic [7:0]    last_byte;
    int            nvec, nerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [RS-1:0] b, input int pos);
        int            sh;
        logic [RS-1:0] t;
`ifdef BYTE_REPEATER_MSB_FIRST_EN
        sh = NB - 1 - pos;
`else
        sh = pos;
`endif
        t = b >> (8 * sh);
        return t[7:0];
    endfunction

    // compare process: model update, output checks and UART consumer model
    initial begin : cmp
        bit            v;
        bit            r;
        bit            ep;
        logic [RS-1:0] d;
        int            avail;
        bus.request_next_byte_in = 1'b1;
        busy = 0;
        last_byte = 8'h00;
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) begin
                #1;
                chk("rst_valid_out", 32'(bus.valid_out), 0);
                chk("rst_data_out", 32'(bus.data_out), 0);
                chk("rst_frame_done", 32'(bus.frame_done_out), 0);
                chk("rst_overflow", 32'(bus.overflow_out), 0);
                blk_q.delete();
                occ = 0; bpos = 0; fc = 0; busy = 0;
                pop_pending = 0; exp_ovf = 0; last_byte = 8'h00;
                bus.request_next_byte_in = !stall;
            end else begin
                v = bus.valid_in;
                d = bus.data_in;
                r = bus.request_next_byte_in;
                #1;
                cyc++;
                if (pop_pending) begin
                    occ--;
                    pop_pending = 0;
                end
                avail = blk_q.size();
                if (v) begin
                    if (occ < DEPTH) begin
                        occ++;
                        blk_q.push_back(d);
                        last_push_cyc = cyc;
                    end else begin
                        exp_ovf = 1;
                    end
                end
                ep = r && (avail > 0);
                chk("valid_out", 32'(bus.valid_out), 32'(ep));
                chk("overflow_out", 32'(bus.overflow_out), 32'(exp_ovf));
                if (bus.valid_out && ep) begin
                    chk("data_out", 32'(bus.data_out), 32'(byte_of(blk_q[0], bpos)));
                    chk("frame_done", 32'(bus.frame_done_out), 32'(fc == FB - 1));
                    got.push_back(bus.data_out);
                    pcyc.push_back(cyc);
                    if (bus.frame_done_out) fd_idx.push_back(got.size() - 1);
                    last_byte = byte_of(blk_q[0], bpos);
                    fc = (fc + 1) % FB;
                    bpos++;
                    if (bpos == NB) begin
                        bpos = 0;
                        void'(blk_q.pop_front());
                        pop_pending = 1;
                    end
                end else begin
                    chk("frame_done_idle", 32'(bus.frame_done_out), 0);
                    chk("data_hold", 32'(bus.data_out), 32'(last_byte));
                end
                if (bus.valid_out) begin
                    busy = (fixed_busy > 0) ? fixed_busy : $urandom_range(1, 6);
                end else if (busy > 0) begin
                    busy--;
                end
                bus.request_next_byte_in = (busy == 0) && !stall;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", nvec);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #3;
    endtask

    task automatic push(input logic [RS-1:0] d);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        cycles(1);
        bus.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cycles(2);
        rst_in = 1'b0;
        cycles(1);
    endtask

    task automatic drain();
        stall = 0;
        for (int i = 0; i < 20000 && blk_q.size() != 0; i++) cycles(1);
        chk("drain_left", 32'(blk_q.size()), 0);
        cycles(4);
    endtask

    // stimulus
    initial begin : stim
        int         s;
        int         f;
        logic [7:0] e1 [4];
        logic [7:0] e5 [4];
`ifdef BYTE_REPEATER_MSB_FIRST_EN
        e1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        e5 = '{8'h11, 8'h22, 8'h33, 8'h44};
`else
        e1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        e5 = '{8'h44, 8'h33, 8'h22, 8'h11};
`endif
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        stall = 0;
        fixed_busy = 3;
        cycles(3);
        rst_in = 1'b0;
        cycles(2);

        // single block, idle consumer
        s = got.size();
        push(32'hA1B2C3D4);
        drain();
        chk("t1_count", 32'(got.size() - s), 4);
        for (int i = 0; i < 4; i++)
            if (s + i < got.size()) chk("t1_byte", 32'(got[s+i]), 32'(e1[i]));
        if (s < pcyc.size()) chk("t1_latency", 32'(pcyc[s] - last_push_cyc + 1), 2);

        // stalled consumer, three blocks
        stall = 1;
        cycles(2);
        s = got.size();
        for (int i = 0; i < 3; i++) push($urandom);
        cycles(20);
        chk("t2_stalled", 32'(got.size() - s), 0);
        drain();
        chk("t2_count", 32'(got.size() - s), 12);

        // overflow on block DEPTH+1
        do_reset();
        stall = 1;
        cycles(2);
        s = got.size();
        for (int i = 0; i < DEPTH; i++) push($urandom);
        chk("t3_ovf_full", 32'(bus.overflow_out), 0);
        push($urandom);
        chk("t3_ovf_drop", 32'(bus.overflow_out), 1);
        fixed_busy = 0;
        drain();
        chk("t3_count", 32'(got.size() - s), 4 * DEPTH);

        // full number streamed through a 10-cycle UART
        do_reset();
        fixed_busy = 10;
        s = got.size();
        f = fd_idx.size();
        for (int i = 0; i < DEPTH; i++) push($urandom);
        drain();
        chk("t4_count", 32'(got.size() - s), FB);
        chk("t4_frame_done_cnt", 32'(fd_idx.size() - f), 1);
        if (f < fd_idx.size()) chk("t4_frame_done_pos", 32'(fd_idx[f] - s), FB - 1);

        // asynchronous reset in the middle of a block
        fixed_busy = 3;
        s = got.size();
        push(32'hDEADBEEF);
        for (int i = 0; i < 200 && got.size() - s < 2; i++) cycles(1);
        chk("t5_partial", 32'(got.size() - s), 2);
        do_reset();
        s = got.size();
        push(32'h11223344);
        drain();
        chk("t5_count", 32'(got.size() - s), 4);
        for (int i = 0; i < 4; i++)
            if (s + i < got.size()) chk("t5_byte", 32'(got[s+i]), 32'(e5[i]));

        // push into a full FIFO on the very cycle it pops
        do_reset();
        stall = 1;
        cycles(2);
        for (int i = 0; i < DEPTH; i++) push($urandom);
        fixed_busy = 0;
        s = got.size();
        stall = 0;
        for (int i = 0; i < 500 && got.size() - s < NB; i++) cycles(1);
        push($urandom);
        chk("t6_no_ovf", 32'(bus.overflow_out), 0);
        drain();
        chk("t6_count", 32'(got.size() - s), 4 * (DEPTH + 1));

        // random traffic with stalls
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) push($urandom);
            else cycles(1);
            if ($urandom_range(0, 99) == 0) stall = !stall;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
